dmem_bus_interface: RTL
=======================

Name: dmem_bus_interface

Overview:
- Sits directly downstream of the load/store unit, between its memory-side outputs (word-aligned address, shifted write data, byte write mask) and the external data-memory bus.
- Converts each single-cycle access request into a registered request/acknowledge bus transaction, and stalls the pipeline until the bus responds.
- Returns the raw 32-bit read word to the MEM stage. Each misaligned beat arrives as a separate request.
- Reports bus errors and acknowledge timeouts.

Parameters:
- TIMEOUT, 16: max cycles bus_req_o may stay high without ack or err before abort; 0 disables the timeout.
- CNT_W, 5: width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  core clock
- reset_i  input  1  asynchronous active-low reset
- req_i  input  1  LSU access valid this cycle (load or store)
- we_i  input  1  1 = store, 0 = load
- addr_i  input  32  word-aligned address from LSU
- wdata_i  input  32  byte-lane-positioned store data
- wmask_i  input  4  byte write mask (ignored for loads)
- stall_o  output  1  hold pipeline (EX/MEM) this cycle
- rdata_o  output  32  captured read word
- rdata_valid_o  output  1  one-cycle pulse: rdata_o updated by a completed load
- err_o  output  1  one-cycle pulse: transaction ended by bus_err_i or timeout
- bus_req_o  output  1  bus request
- bus_we_o  output  1  bus write enable
- bus_addr_o  output  32  bus address
- bus_wdata_o  output  32  bus write data
- bus_wmask_o  output  4  bus byte mask
- bus_ack_i  input  1  bus completion
- bus_err_i  input  1  bus error completion
- bus_rdata_i  input  32  bus read data, valid with bus_ack_i

Behaviour:
- Reset (reset_i low, async): state IDLE. All registered outputs are 0: bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o, rdata_o, rdata_valid_o, err_o. Timeout counter is 0.
- stall_o is combinational: 1 when (state==IDLE and req_i) or state==BUSY, else 0. It is 0 during reset.
- IDLE, req_i=1 at a rising edge:
  - Latch addr_i, wdata_i, we_i into bus_* registers.
  - bus_wmask_o = we_i ? wmask_i : 4'b0000.
  - bus_req_o <= 1, counter <= 0, state -> BUSY.
- IDLE, req_i=0: no change.
- BUSY:
  - bus_* fields are held stable while bus_req_o is high.
  - Counter increments each cycle and saturates.
- BUSY exit, priority order at each edge:
  - bus_err_i=1 (wins over simultaneous ack): bus_req_o<=0, err_o<=1, rdata_o<=0, state->IDLE.
  - Else bus_ack_i=1: bus_req_o<=0, state->IDLE. For a load, rdata_o<=bus_rdata_i and rdata_valid_o<=1. For a store, rdata_o is unchanged and rdata_valid_o stays 0.
  - Else TIMEOUT!=0 and counter==TIMEOUT-1: abort exactly as the error case.
- Pulse width: rdata_valid_o and err_o are high for exactly one cycle, then return to 0.
- Latency (zero-wait bus that acks in the first cycle req is seen):
  - Request sampled at edge 0; bus_req_o high during cycle 1; ack sampled at edge 1.
  - rdata_valid_o high and stall_o low in cycle 2.
  - Minimum 2-cycle stall per access; each wait state adds 1.
- New access in the response cycle: a req_i present in the cycle after completion is accepted normally from IDLE. Back-to-back misaligned beats therefore cost 2 cycles each.
- Ack/err/rdata while in IDLE are ignored: no output change.
- Reset asserted mid-transaction: bus_req_o drops immediately and no pulse is generated. The bus is expected to discard the request.

Test Plan:
- Zero-wait load: req_i=1, we_i=0, addr_i=0x100; bus acks in its first cycle with rdata 0xDEADBEEF. Required: bus_addr_o=0x100, bus_wmask_o=0; rdata_o=0xDEADBEEF with rdata_valid_o pulse exactly 2 cycles after req; stall_o high 2 cycles.
- Store with 3 wait states: addr 0x204, wdata 0x0000AB00, wmask 4'b0010. Required: bus fields stable for 4 cycles; no rdata_valid_o; rdata_o unchanged; stall_o released in the cycle after ack.
- Simultaneous bus_ack_i and bus_err_i on a load: err_o pulses; rdata_o=0; rdata_valid_o stays 0.
- Timeout with TIMEOUT=4 and no ack: bus_req_o high exactly 4 cycles, then err_o pulses; a later stray ack is ignored.
- Misaligned pair: two requests (0x0, then 0x4) issued in the first free cycles. Required: two bus transactions with the correct addresses, two rdata_valid_o pulses 2 cycles apart.
- Reset pulse during a BUSY wait: bus_req_o falls asynchronously; after release, all outputs are 0, state is IDLE, and a new load completes normally.

Source files
------------

// File: rtl/dmem_bus_interface.sv
// dmem_bus_interface
// Bridges the load/store unit's single-cycle memory requests onto a
// registered request/acknowledge data-memory bus. Each accepted access holds
// the pipeline until the bus completes it with an ack, an error, or an
// acknowledge timeout. Loads return the raw 32-bit word; errors and timeouts
// are reported as one-cycle pulses.

module dmem_bus_interface #(
  parameter int unsigned TIMEOUT = 16,  // max bus_req_o cycles before abort, 0 = never
  parameter int unsigned CNT_W   = 5    // timeout counter width, 2**CNT_W > TIMEOUT
) (
  input  logic        clk_i,
  input  logic        reset_i,        // asynchronous, active low

  // load/store unit side
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_o,

  // data-memory bus side
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wmask_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_rdata_i
);

  // Two-state controller: waiting for an LSU request, or owning the bus.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [31:0]      r_bus_wdata;
  logic [3:0]       r_bus_wmask;

  logic [31:0]      r_rdata;
  logic             r_rdata_valid;
  logic             r_err;

  logic             w_idle;
  logic             w_busy;
  logic             w_accept;
  logic             w_timeout_hit;
  logic             w_abort;
  logic             w_ack_ok;
  logic             w_done;
  logic [3:0]       w_req_mask;

  assign w_idle   = (r_state == S_IDLE);
  assign w_busy   = (r_state == S_BUSY);
  assign w_accept = w_idle && req_i;

  // Loads never drive byte enables onto the bus, whatever the LSU presents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
    assign w_req_mask[gi] = we_i & wmask_i[gi];
  end

  // Timeout fires on the edge where bus_req_o would otherwise begin its
  // (TIMEOUT+1)-th cycle, so the request is visible for exactly TIMEOUT cycles.
  if (TIMEOUT != 0) begin : g_timeout
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
    assign w_timeout_hit = (r_cnt == LP_CNT_LAST);
  end else begin : g_no_timeout
    assign w_timeout_hit = 1'b0;
  end

  // Completion priority: error beats ack, ack beats timeout.
  assign w_abort  = w_busy && (bus_err_i || (!bus_ack_i && w_timeout_hit));
  assign w_ack_ok = w_busy && !bus_err_i && bus_ack_i;
  assign w_done   = w_abort || w_ack_ok;

  // The pipeline is held from the request cycle until the bus completes;
  // while reset is asserted nothing is stalled.
  assign stall_o = reset_i && (w_accept || w_busy);

  assign bus_req_o     = r_bus_req;
  assign bus_we_o      = r_bus_we;
  assign bus_addr_o    = r_bus_addr;
  assign bus_wdata_o   = r_bus_wdata;
  assign bus_wmask_o   = r_bus_wmask;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rdata_valid;
  assign err_o         = r_err;

  // Controller state: enter BUSY on an accepted request, leave on completion.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_state <= S_BUSY;
    end else if (w_done) begin
      r_state <= S_IDLE;
    end
  end

  // Cycles spent waiting on the bus; restarts per access and saturates.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_busy && (r_cnt != '1)) begin
      r_cnt <= r_cnt + LP_CNT_ONE;
    end
  end

  // Bus request fields: captured on acceptance and held until completion.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wmask <= '0;
    end else if (w_accept) begin
      r_bus_req   <= 1'b1;
      r_bus_we    <= we_i;
      r_bus_addr  <= addr_i;
      r_bus_wdata <= wdata_i;
      r_bus_wmask <= w_req_mask;
    end else if (w_done) begin
      r_bus_req   <= 1'b0;
    end
  end

  // Response side: one-cycle pulses, read data captured only on a clean load ack.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
      if (w_abort) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end else if (w_ack_ok && !r_bus_we) begin
        r_rdata       <= bus_rdata_i;
        r_rdata_valid <= 1'b1;
      end
    end
  end

endmodule
